// File: rtl/pattern_stream_ctrl.sv
// Serializes valid/ready words MSB-first into an overlapping programmable pattern detector with saturating match counter.
// Latency: first bit one cycle after acceptance; match pulse one cycle after the completing bit is sampled.
// Backpressure: in_ready only in IDLE or on the last bit of a word, so back-to-back words stream gap-free.
module pattern_stream_ctrl #(
    parameter int W    = 8,
    parameter int PMAX = 8,
    localparam int LW  = $clog2(PMAX + 1),
    localparam int CW  = $clog2(W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_load,
    input  logic [PMAX-1:0] cfg_pattern,
    input  logic [LW-1:0]   cfg_len,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    output logic            in_ready,
    output logic            bit_out,
    output logic            bit_valid,
    output logic            match,
    output logic [15:0]     match_count,
    input  logic            count_clr,
    output logic            busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    shreg, shreg_nxt;
    logic [CW-1:0]   bit_cnt, cnt_nxt;
    logic [PMAX-1:0] pattern, hist, hist_nxt, len_mask;
    logic [LW-1:0]   len, fill, fill_nxt, cfg_len_clamped;
    logic            cfg_accept, hit;

    assign in_ready  = (state == IDLE) || (bit_cnt == '0);
    assign bit_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign bit_out   = shreg[W-1];

    // Config only lands when nothing is in flight and no word is being offered.
    assign cfg_accept      = cfg_load && (state == IDLE) && !in_valid;
    assign cfg_len_clamped = (cfg_len > LW'(PMAX)) ? LW'(PMAX) : cfg_len;

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shreg_nxt = in_data;
                    cnt_nxt   = CW'(W - 1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shreg_nxt = shreg << 1;
                cnt_nxt   = bit_cnt - CW'(1);
                if (bit_cnt == '0) begin
                    if (in_valid) begin
                        shreg_nxt = in_data;
                        cnt_nxt   = CW'(W - 1);
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Detector view of history after the current bit is absorbed.
    always_comb begin
        hist_nxt = PMAX'({hist, bit_out});
        fill_nxt = (fill == LW'(PMAX)) ? fill : fill + LW'(1);
        for (int i = 0; i < PMAX; i++) begin
            len_mask[i] = (i < int'(len));
        end
        hit = (len != '0) && (fill_nxt >= len) &&
              (((hist_nxt ^ pattern) & len_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern     <= '0;
            len         <= '0;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            if (cfg_accept) begin
                pattern <= cfg_pattern;
                len     <= cfg_len_clamped;
                hist    <= '0;
                fill    <= '0;
            end else if (bit_valid) begin
                hist <= hist_nxt;
                fill <= fill_nxt;
            end
            match <= bit_valid && hit;
            if (count_clr) begin
                match_count <= '0;
            end else if (bit_valid && hit && (match_count != 16'hFFFF)) begin
                match_count <= match_count + 16'd1;
            end
        end
    end

endmodule
